// File: rtl/cache_arb_pkg.sv
// Shared definitions for the cache/memory arbiter: state encoding,
// requester ids, bus widths and a bank helper.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN0  = 2'd1,
    ST_OWN1  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_t;

  localparam logic REQ_R0 = 1'b0;  // dcache
  localparam logic REQ_R1 = 1'b1;  // icache

  localparam int NUM_BANKS = 4;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;

  function automatic logic banks_idle(input logic [NUM_BANKS-1:0] busy);
    return (busy == '0);
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the two cache controllers, the arbiter and the memory.
// The slave modport is the arbiter's view; master is the caches + memory side.
interface cache_mem_arbiter_if;
  import cache_arb_pkg::*;

  // rX_req is a hold request: it stays high for the whole burst; rX_gnt is
  // the registered ownership grant. Strobes are forwarded only while rX_gnt=1.
  logic                 r0_req,      r1_req;
  logic [ADDR_W-1:0]    r0_addr,     r1_addr;
  logic [DATA_W-1:0]    r0_data_in,  r1_data_in;
  logic                 r0_wr,       r1_wr;
  logic                 r0_rd,       r1_rd;
  logic                 r0_gnt,      r1_gnt;
  logic [DATA_W-1:0]    r0_data_out, r1_data_out;
  logic [NUM_BANKS-1:0] r0_busy,     r1_busy;
  logic                 r0_stall,    r1_stall;
  logic                 r0_err,      r1_err;

  logic [ADDR_W-1:0]    m_addr;
  logic [DATA_W-1:0]    m_data_in;
  logic                 m_wr, m_rd;
  logic [DATA_W-1:0]    m_data_out;
  logic [NUM_BANKS-1:0] m_busy;
  logic                 m_stall, m_err;

  modport slave (
    input  r0_req, r0_addr, r0_data_in, r0_wr, r0_rd,
    input  r1_req, r1_addr, r1_data_in, r1_wr, r1_rd,
    output r0_gnt, r0_data_out, r0_busy, r0_stall, r0_err,
    output r1_gnt, r1_data_out, r1_busy, r1_stall, r1_err,
    output m_addr, m_data_in, m_wr, m_rd,
    input  m_data_out, m_busy, m_stall, m_err
  );

  modport master (
    output r0_req, r0_addr, r0_data_in, r0_wr, r0_rd,
    output r1_req, r1_addr, r1_data_in, r1_wr, r1_rd,
    input  r0_gnt, r0_data_out, r0_busy, r0_stall, r0_err,
    input  r1_gnt, r1_data_out, r1_busy, r1_stall, r1_err,
    input  m_addr, m_data_in, m_wr, m_rd,
    output m_data_out, m_busy, m_stall, m_err
  );

endinterface

// File: rtl/arb_hold_timer.sv
// Counts consecutive owned cycles and flags the last one allowed
// before a forced release. MAX_HOLD=0 disables the limit.
module arb_hold_timer #(
  parameter int MAX_HOLD = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_timeout
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] LIMIT = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;

  logic [CW-1:0] r_cnt;

  assign o_timeout = (MAX_HOLD > 0) && i_en && (r_cnt == LIMIT);

  // Clearing on timeout keeps the count inside CW bits; ownership always
  // passes through IDLE/DRAIN before the next grant anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_en || o_timeout || (MAX_HOLD == 0)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Whole-burst arbiter between the dcache (r0) and icache (r1) for the shared
// four-bank memory; drains outstanding bank activity before re-granting.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int FAIR     = 1,
  parameter int MAX_HOLD = 0
) (
  input  logic               clk,
  input  logic               rst,
  cache_mem_arbiter_if.slave bus,
  output arb_state_t         o_state
);

  arb_state_t r_state;
  logic       r_last_owner;
  logic       r_rr_ptr;
  logic       r_r0_block;
  logic       r_r1_block;

  logic w_own0, w_own1, w_owning, w_drain;
  logic w_route0, w_route1;
  logic w_owner_id, w_owner_req;
  logic w_timeout, w_expired, w_release;
  logic w_elig0, w_elig1;
  logic w_banks_idle;

  assign w_own0       = (r_state == ST_OWN0);
  assign w_own1       = (r_state == ST_OWN1);
  assign w_owning     = w_own0 | w_own1;
  assign w_drain      = (r_state == ST_DRAIN);
  assign w_owner_id   = w_own1 ? REQ_R1 : REQ_R0;
  assign w_owner_req  = w_own1 ? bus.r1_req : bus.r0_req;
  assign w_elig0      = bus.r0_req & ~r_r0_block;
  assign w_elig1      = bus.r1_req & ~r_r1_block;
  assign w_banks_idle = banks_idle(bus.m_busy);

  // Responses follow the owner, and during DRAIN the last owner, so that
  // reads still in flight at release are delivered to the right cache.
  assign w_route0 = w_own0 | (w_drain & (r_last_owner == REQ_R0));
  assign w_route1 = w_own1 | (w_drain & (r_last_owner == REQ_R1));

  arb_hold_timer #(.MAX_HOLD(MAX_HOLD)) u_hold_timer (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_owning),
    .o_timeout (w_timeout)
  );

  assign w_expired = w_timeout & w_owner_req;
  assign w_release = w_owning & (~w_owner_req | w_expired);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_owner <= REQ_R0;
      r_rr_ptr     <= REQ_R0;
      r_r0_block   <= 1'b0;
      r_r1_block   <= 1'b0;
    end else begin
      if (!bus.r0_req) r_r0_block <= 1'b0;
      if (!bus.r1_req) r_r1_block <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_elig0 && w_elig1) begin
            r_state <= ((FAIR != 0) && (r_rr_ptr == REQ_R1)) ? ST_OWN1 : ST_OWN0;
          end else if (w_elig0) begin
            r_state <= ST_OWN0;
          end else if (w_elig1) begin
            r_state <= ST_OWN1;
          end
        end
        ST_OWN0, ST_OWN1: begin
          if (w_release) begin
            r_last_owner <= w_owner_id;
            r_rr_ptr     <= ~w_owner_id;
            r_state      <= w_banks_idle ? ST_IDLE : ST_DRAIN;
            // Only a forced release arrives here with req still high.
            if (w_owner_req) begin
              if (w_owner_id == REQ_R1) r_r1_block <= 1'b1;
              else                      r_r0_block <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (w_banks_idle) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_state    = r_state;
  assign bus.r0_gnt = w_own0;
  assign bus.r1_gnt = w_own1;

  // Simultaneous wr and rd from the owner is rejected rather than guessed at.
  always_comb begin
    bus.m_addr    = '0;
    bus.m_data_in = '0;
    bus.m_wr      = 1'b0;
    bus.m_rd      = 1'b0;
    if (w_own0) begin
      bus.m_addr    = bus.r0_addr;
      bus.m_data_in = bus.r0_data_in;
      bus.m_wr      = bus.r0_wr & ~bus.r0_rd;
      bus.m_rd      = bus.r0_rd & ~bus.r0_wr;
    end else if (w_own1) begin
      bus.m_addr    = bus.r1_addr;
      bus.m_data_in = bus.r1_data_in;
      bus.m_wr      = bus.r1_wr & ~bus.r1_rd;
      bus.m_rd      = bus.r1_rd & ~bus.r1_wr;
    end
  end

  assign bus.r0_data_out = w_route0 ? bus.m_data_out : '0;
  assign bus.r1_data_out = w_route1 ? bus.m_data_out : '0;
  assign bus.r0_busy     = w_route0 ? bus.m_busy : '0;
  assign bus.r1_busy     = w_route1 ? bus.m_busy : '0;
  assign bus.r0_stall    = w_route0 ? bus.m_stall : 1'b1;
  assign bus.r1_stall    = w_route1 ? bus.m_stall : 1'b1;

  assign bus.r0_err = (w_route0 & bus.m_err)
                    | (w_own0 & bus.r0_wr & bus.r0_rd)
                    | (w_own0 & w_expired);
  assign bus.r1_err = (w_route1 & bus.m_err)
                    | (w_own1 & bus.r1_wr & bus.r1_rd)
                    | (w_own1 & w_expired);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: three instances cover FAIR=1,
// FAIR=0 and MAX_HOLD=8; each scenario task checks hand-computed values.
module tb_cache_mem_arbiter;
  import cache_arb_pkg::*;

  logic       clk;
  logic       rst;
  arb_state_t st_a, st_b, st_c;
  int         n_cmp;
  int         n_fail;

  cache_mem_arbiter_if ifa ();
  cache_mem_arbiter_if ifb ();
  cache_mem_arbiter_if ifc ();

  cache_mem_arbiter #(.FAIR(1), .MAX_HOLD(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa), .o_state(st_a));
  cache_mem_arbiter #(.FAIR(0), .MAX_HOLD(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb), .o_state(st_b));
  cache_mem_arbiter #(.FAIR(1), .MAX_HOLD(8)) dut_c (.clk(clk), .rst(rst), .bus(ifc), .o_state(st_c));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ifa.r0_req = 0; ifa.r0_addr = '0; ifa.r0_data_in = '0; ifa.r0_wr = 0; ifa.r0_rd = 0;
    ifa.r1_req = 0; ifa.r1_addr = '0; ifa.r1_data_in = '0; ifa.r1_wr = 0; ifa.r1_rd = 0;
    ifa.m_data_out = '0; ifa.m_busy = '0; ifa.m_stall = 0; ifa.m_err = 0;
    ifb.r0_req = 0; ifb.r0_addr = '0; ifb.r0_data_in = '0; ifb.r0_wr = 0; ifb.r0_rd = 0;
    ifb.r1_req = 0; ifb.r1_addr = '0; ifb.r1_data_in = '0; ifb.r1_wr = 0; ifb.r1_rd = 0;
    ifb.m_data_out = '0; ifb.m_busy = '0; ifb.m_stall = 0; ifb.m_err = 0;
    ifc.r0_req = 0; ifc.r0_addr = '0; ifc.r0_data_in = '0; ifc.r0_wr = 0; ifc.r0_rd = 0;
    ifc.r1_req = 0; ifc.r1_addr = '0; ifc.r1_data_in = '0; ifc.r1_wr = 0; ifc.r1_rd = 0;
    ifc.m_data_out = '0; ifc.m_busy = '0; ifc.m_stall = 0; ifc.m_err = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifa.m_data_out = 16'hBEEF; ifa.m_busy = 4'hF; ifa.m_err = 1; ifa.m_stall = 0;
    ifa.r0_req = 1; ifa.r0_rd = 1;
    tick(); #1;
    if ({ifa.r0_gnt, ifa.r1_gnt, ifa.m_wr, ifa.m_rd} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_gnt_strobe: got %b want 0000", {ifa.r0_gnt, ifa.r1_gnt, ifa.m_wr, ifa.m_rd});
    end
    n_cmp++;
    if ({ifa.r0_data_out, ifa.r0_busy, ifa.r0_stall, ifa.r0_err, ifa.r1_stall} !== {16'h0, 4'h0, 1'b1, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL reset_route: got %h/%h/%b/%b/%b want 0000/0/1/0/1", ifa.r0_data_out, ifa.r0_busy, ifa.r0_stall, ifa.r0_err, ifa.r1_stall);
    end
    n_cmp++;
    if ({st_a, st_b, st_c, ifa.m_addr} !== {ST_IDLE, ST_IDLE, ST_IDLE, 16'h0}) begin
      n_fail++; $display("FAIL reset_state: got %0d %0d %0d addr %h want 0 0 0 0000", st_a, st_b, st_c, ifa.m_addr);
    end
    n_cmp++;
    clear_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    ifa.r0_req = 1; ifa.r0_rd = 1; ifa.r0_addr = 16'h0010;
    ifa.m_data_out = 16'h1111; ifa.m_busy = 4'b0001;
    #1;
    if ({ifa.r0_gnt, ifa.m_rd} !== 2'b00) begin
      n_fail++; $display("FAIL single_latency: gnt/m_rd got %b want 00", {ifa.r0_gnt, ifa.m_rd});
    end
    n_cmp++;
    tick(); #1;
    if ({ifa.r0_gnt, ifa.r1_gnt, ifa.m_rd, ifa.m_addr} !== {3'b101, 16'h0010}) begin
      n_fail++; $display("FAIL single_grant: got %b addr %h want 101 addr 0010", {ifa.r0_gnt, ifa.r1_gnt, ifa.m_rd}, ifa.m_addr);
    end
    n_cmp++;
    if ({ifa.r0_data_out, ifa.r0_busy, ifa.r0_stall} !== {16'h1111, 4'b0001, 1'b0}) begin
      n_fail++; $display("FAIL single_route: got %h/%b/%b want 1111/0001/0", ifa.r0_data_out, ifa.r0_busy, ifa.r0_stall);
    end
    n_cmp++;
    if ({ifa.r1_stall, ifa.r1_busy, ifa.r1_data_out} !== {1'b1, 4'h0, 16'h0}) begin
      n_fail++; $display("FAIL single_nonowner: got %b/%b/%h want 1/0000/0000", ifa.r1_stall, ifa.r1_busy, ifa.r1_data_out);
    end
    n_cmp++;
    for (int i = 1; i < 4; i++) begin
      ifa.r0_addr = 16'h0010 + 16'(2 * i);
      ifa.m_busy  = 4'(1 << i);
      tick(); #1;
      if ({ifa.m_addr, ifa.r0_busy, ifa.r1_busy} !== {16'h0010 + 16'(2 * i), 4'(1 << i), 4'h0}) begin
        n_fail++; $display("FAIL single_burst_%0d: addr %h busy %b/%b", i, ifa.m_addr, ifa.r0_busy, ifa.r1_busy);
      end
      n_cmp++;
    end
    ifa.r0_req = 0; ifa.r0_addr = 16'h0018; ifa.m_busy = 4'h0;
    #1;
    if ({ifa.r0_gnt, ifa.m_rd, ifa.m_addr} !== {2'b11, 16'h0018}) begin
      n_fail++; $display("FAIL single_drop_cycle: got %b addr %h want 11 addr 0018", {ifa.r0_gnt, ifa.m_rd}, ifa.m_addr);
    end
    n_cmp++;
    tick(); ifa.r0_rd = 0; #1;
    if ({st_a, ifa.r0_gnt} !== {ST_IDLE, 1'b0}) begin
      n_fail++; $display("FAIL single_release: state %0d gnt %b want 0 0", st_a, ifa.r0_gnt);
    end
    n_cmp++;
  endtask

  task automatic test_fair_drain();
    do_reset();
    ifa.r0_req = 1; ifa.r1_req = 1;
    tick(); #1;
    if ({st_a, ifa.r0_gnt, ifa.r1_gnt} !== {ST_OWN0, 2'b10}) begin
      n_fail++; $display("FAIL fair_first: state %0d gnt %b want 1 10", st_a, {ifa.r0_gnt, ifa.r1_gnt});
    end
    n_cmp++;
    ifa.r0_req = 0; ifa.m_busy = 4'b0100; ifa.m_data_out = 16'hD0D0;
    ifa.r1_rd = 1; ifa.r1_addr = 16'h0200;
    tick(); #1;
    if ({st_a, ifa.r0_gnt, ifa.r1_gnt, ifa.m_rd} !== {ST_DRAIN, 3'b000}) begin
      n_fail++; $display("FAIL drain_enter: state %0d gnt/m_rd %b want 3 000", st_a, {ifa.r0_gnt, ifa.r1_gnt, ifa.m_rd});
    end
    n_cmp++;
    if ({ifa.r0_data_out, ifa.r0_busy, ifa.r1_stall, ifa.r1_data_out} !== {16'hD0D0, 4'b0100, 1'b1, 16'h0}) begin
      n_fail++; $display("FAIL drain_route: got %h/%b/%b/%h want d0d0/0100/1/0000", ifa.r0_data_out, ifa.r0_busy, ifa.r1_stall, ifa.r1_data_out);
    end
    n_cmp++;
    tick(); #1;
    if (st_a !== ST_DRAIN) begin
      n_fail++; $display("FAIL drain_hold: state %0d want 3", st_a);
    end
    n_cmp++;
    ifa.m_busy = 4'h0;
    tick(); #1;
    if ({st_a, ifa.r1_gnt} !== {ST_IDLE, 1'b0}) begin
      n_fail++; $display("FAIL drain_exit: state %0d r1_gnt %b want 0 0", st_a, ifa.r1_gnt);
    end
    n_cmp++;
    tick(); #1;
    if ({ifa.r0_gnt, ifa.r1_gnt, ifa.m_rd, ifa.m_addr} !== {3'b011, 16'h0200}) begin
      n_fail++; $display("FAIL fair_second: got %b addr %h want 011 addr 0200", {ifa.r0_gnt, ifa.r1_gnt, ifa.m_rd}, ifa.m_addr);
    end
    n_cmp++;
    ifa.r1_req = 0; ifa.r1_rd = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    ifa.r0_req = 1; ifa.r1_req = 1; ifb.r0_req = 1; ifb.r1_req = 1;
    tick(); #1;
    if ({ifa.r0_gnt, ifa.r1_gnt, ifb.r0_gnt, ifb.r1_gnt} !== 4'b1010) begin
      n_fail++; $display("FAIL b2b_first: got %b want 1010", {ifa.r0_gnt, ifa.r1_gnt, ifb.r0_gnt, ifb.r1_gnt});
    end
    n_cmp++;
    ifa.r0_req = 0; ifb.r0_req = 0;
    tick(); #1;
    if ({st_a, st_b, ifa.r1_gnt} !== {ST_IDLE, ST_IDLE, 1'b0}) begin
      n_fail++; $display("FAIL b2b_release: states %0d %0d r1_gnt %b want 0 0 0", st_a, st_b, ifa.r1_gnt);
    end
    n_cmp++;
    ifa.r0_req = 1; ifb.r0_req = 1;
    tick(); #1;
    if ({ifa.r0_gnt, ifa.r1_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL b2b_fair: got %b want 01", {ifa.r0_gnt, ifa.r1_gnt});
    end
    n_cmp++;
    if ({ifb.r0_gnt, ifb.r1_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_fixed: got %b want 10", {ifb.r0_gnt, ifb.r1_gnt});
    end
    n_cmp++;
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_wr_rd_conflict();
    ifa.r0_req = 1;
    tick(); #1;
    ifa.r0_wr = 1; ifa.r0_rd = 1; ifa.r0_addr = 16'h00F0; ifa.r0_data_in = 16'hA5A5;
    #1;
    if ({ifa.m_wr, ifa.m_rd, ifa.r0_err, ifa.r1_err, ifa.m_addr} !== {4'b0010, 16'h00F0}) begin
      n_fail++; $display("FAIL conflict_cycle: wr/rd/err0/err1 %b addr %h want 0010 addr 00f0", {ifa.m_wr, ifa.m_rd, ifa.r0_err, ifa.r1_err}, ifa.m_addr);
    end
    n_cmp++;
    ifa.r0_rd = 0;
    tick(); #1;
    if ({st_a, ifa.m_wr, ifa.m_rd, ifa.r0_err, ifa.m_data_in} !== {ST_OWN0, 3'b100, 16'hA5A5}) begin
      n_fail++; $display("FAIL conflict_after: state %0d wr/rd/err %b data %h want 1 100 a5a5", st_a, {ifa.m_wr, ifa.m_rd, ifa.r0_err}, ifa.m_data_in);
    end
    n_cmp++;
    ifa.r0_req = 0; ifa.r0_wr = 0;
    tick();
  endtask

  task automatic test_hold_timeout();
    ifc.r1_req = 1;
    tick(); #1;
    for (int k = 1; k < 8; k++) begin
      if ({ifc.r1_gnt, ifc.r1_err} !== 2'b10) begin
        n_fail++; $display("FAIL hold_cycle_%0d: gnt/err %b want 10", k, {ifc.r1_gnt, ifc.r1_err});
      end
      n_cmp++;
      tick(); #1;
    end
    if ({ifc.r1_gnt, ifc.r1_err} !== 2'b11) begin
      n_fail++; $display("FAIL hold_expire: gnt/err %b want 11", {ifc.r1_gnt, ifc.r1_err});
    end
    n_cmp++;
    tick(); #1;
    if ({st_c, ifc.r1_gnt, ifc.r1_err} !== {ST_IDLE, 2'b00}) begin
      n_fail++; $display("FAIL hold_forced: state %0d gnt/err %b want 0 00", st_c, {ifc.r1_gnt, ifc.r1_err});
    end
    n_cmp++;
    for (int k = 0; k < 10; k++) begin
      tick(); #1;
      if (ifc.r1_gnt !== 1'b0) begin
        n_fail++; $display("FAIL hold_blocked_%0d: gnt %b want 0", k, ifc.r1_gnt);
      end
      n_cmp++;
    end
    ifc.r1_req = 0;
    tick();
    ifc.r1_req = 1;
    tick(); #1;
    if (ifc.r1_gnt !== 1'b1) begin
      n_fail++; $display("FAIL hold_regrant: gnt %b want 1", ifc.r1_gnt);
    end
    n_cmp++;
    ifc.r1_req = 0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    ifa.r1_req = 1; ifa.r1_rd = 1; ifa.r1_addr = 16'h1234; ifa.m_busy = 4'b0011;
    tick(); #1;
    if ({ifa.r1_gnt, ifa.m_rd, ifa.m_addr} !== {2'b11, 16'h1234}) begin
      n_fail++; $display("FAIL midrst_own: got %b addr %h want 11 addr 1234", {ifa.r1_gnt, ifa.m_rd}, ifa.m_addr);
    end
    n_cmp++;
    rst = 1'b1;
    #1;
    if ({st_a, ifa.r1_gnt, ifa.m_rd, ifa.m_addr, ifa.r1_stall, ifa.r1_busy} !== {ST_IDLE, 2'b00, 16'h0, 1'b1, 4'h0}) begin
      n_fail++; $display("FAIL midrst_async: state %0d gnt/rd %b addr %h stall %b busy %b", st_a, {ifa.r1_gnt, ifa.m_rd}, ifa.m_addr, ifa.r1_stall, ifa.r1_busy);
    end
    n_cmp++;
    tick();
    rst = 1'b0; ifa.r1_rd = 0; ifa.m_busy = 4'h0; ifa.r0_req = 1; ifa.r1_req = 1;
    tick(); #1;
    if ({ifa.r0_gnt, ifa.r1_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL midrst_regrant: got %b want 10", {ifa.r0_gnt, ifa.r1_gnt});
    end
    n_cmp++;
    clear_inputs();
    tick();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_fair_drain();
    test_back_to_back();
    test_wr_rd_conflict();
    test_hold_timeout();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
